// File: rtl/tinyrisc_pkg.sv
// Shared TinyRISC definitions: control-word bit map, instruction fields and
// architectural sizes used by the register-writeback stage.
package tinyrisc_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 16;
  localparam int AW     = $clog2(NREGS);
  localparam int RA_REG = 15;
  localparam int CTRL_W = 22;
  localparam int CNT_W  = 32;

  localparam int CTRL_ISST     = 0;
  localparam int CTRL_ISLD     = 1;
  localparam int CTRL_ISBEQ    = 2;
  localparam int CTRL_ISBGT    = 3;
  localparam int CTRL_ISRET    = 4;
  localparam int CTRL_ISIMM    = 5;
  localparam int CTRL_ISWB     = 6;
  localparam int CTRL_ISUBR    = 7;
  localparam int CTRL_ISCALL   = 8;
  localparam int CTRL_ALU_LSB  = 9;

  localparam int RD_MSB = 25;
  localparam int RD_LSB = 22;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [AW-1:0]     reg_addr_t;
  typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/rw_wb_select.sv
// Combinational writeback selection: enable, destination register and value
// (call link address, load result or ALU result, in that priority).
module rw_wb_select
  import tinyrisc_pkg::*;
(
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   ld_i,
  input  logic [XLEN-1:0]   alu_i,
  input  logic [XLEN-1:0]   instr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              wb_en_o,
  output logic [AW-1:0]     wb_addr_o,
  output logic [XLEN-1:0]   wb_data_o
);

  always_comb begin
    wb_en_o   = ctrl_i[CTRL_ISWB];
    wb_addr_o = instr_i[RD_MSB:RD_LSB];
    wb_data_o = alu_i;
    if (ctrl_i[CTRL_ISCALL]) begin
      wb_addr_o = AW'(RA_REG);
      wb_data_o = pc_i + XLEN'(4);
    end else if (ctrl_i[CTRL_ISLD]) begin
      wb_data_o = ld_i;
    end
  end

  // Remaining instruction/control bits belong to earlier stages.
  logic unused_bits;
  assign unused_bits = ^{instr_i[XLEN-1:RD_MSB+1], instr_i[RD_LSB-1:0],
                         ctrl_i[CTRL_W-1:CTRL_ISCALL+1], ctrl_i[CTRL_ISWB-1:CTRL_ISLD+1],
                         ctrl_i[CTRL_ISST]};

endmodule

// File: rtl/rw_regfile.sv
// TinyRISC RW stage: 16x32 register file with write-through bypass reads.
// Optional retired-instruction counter enabled by RW_RETIRE_CNT_EN.
module rw_regfile
  import tinyrisc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   ld_i,
  input  logic [XLEN-1:0]   alu_i,
  input  logic [XLEN-1:0]   instr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [AW-1:0]     rs1_addr_i,
  input  logic [AW-1:0]     rs2_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic              wb_en_o,
  output logic [AW-1:0]     wb_addr_o,
  output logic [XLEN-1:0]   wb_data_o
`ifdef RW_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retire_cnt_o
`endif
);

  word_t regs_q [NREGS];

  rw_wb_select u_wb_select (
    .pc_i      (pc_i),
    .ld_i      (ld_i),
    .alu_i     (alu_i),
    .instr_i   (instr_i),
    .ctrl_i    (ctrl_i),
    .wb_en_o   (wb_en_o),
    .wb_addr_o (wb_addr_o),
    .wb_data_o (wb_data_o)
  );

  // One flop bank per register so the async clear applies to every entry.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        regs_q[gi] <= '0;
      end else if (wb_en_o && (wb_addr_o == AW'(gi))) begin
        regs_q[gi] <= wb_data_o;
      end
    end
  end

  assign rs1_data_o = (wb_en_o && (rs1_addr_i == wb_addr_o)) ? wb_data_o : regs_q[rs1_addr_i];
  assign rs2_data_o = (wb_en_o && (rs2_addr_i == wb_addr_o)) ? wb_data_o : regs_q[rs2_addr_i];

`ifdef RW_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ctrl_i != '0) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retire_cnt_o = cnt_q;
`endif

endmodule
